mouse_pos_ctl: RTL and testbench
================================

# mouse_pos_ctl

Frame-synchronous mouse position stage sitting directly upstream of the cursor drawing stage. It captures raw position samples and left-button presses from the PS/2 mouse controller and clamps them to the active 800x600 area. It commits the result to its outputs only at the start of vertical blanking, so the cursor never moves mid-frame. All logic runs in the 40 MHz pixel clock domain.

## Interface
- H_ACTIVE, 800, horizontal active pixels; x clamp limit.
- V_ACTIVE, 600, vertical active lines; y clamp limit.
- clk40MHz  input  1  pixel clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- xpos_raw  input  12  x position from the mouse controller; valid when new_event=1.
- ypos_raw  input  12  y position from the mouse controller; valid when new_event=1.
- new_event  input  1  one-cycle strobe; new raw position sample available.
- left  input  1  left button level, already in the clk40MHz domain.
- vblnk  input  1  vertical blanking level from the timing generator.
- xpos  output  12  committed x, fed to the cursor drawing stage.
- ypos  output  12  committed y.
- update  output  1  one-cycle pulse; xpos/ypos were just committed.
- click  output  1  one-cycle pulse, coincident with update; at least one left press occurred since the previous commit.

## Operation
- Reset: xpos=0, ypos=0, update=0, click=0, state IDLE, shadow regs=0, click_pend=0, vblnk_d=0, left_d=0.
- On every edge with new_event=1, in any state: shadow_x<=clamp(xpos_raw), shadow_y<=clamp(ypos_raw).
- Clamp: value >= limit -> limit-1; otherwise unchanged. Compare is unsigned over 12 bits.
- vb_rise = vblnk & ~vblnk_d. l_rise = left & ~left_d.
- l_rise sets click_pend. click_pend is cleared only on a commit.
- FSM states and transitions:
  - IDLE -> PENDING on new_event or l_rise.
  - PENDING -> COMMIT on vb_rise. Otherwise stay; any further samples overwrite the shadow regs.
  - COMMIT lasts exactly one cycle. At the edge ending COMMIT:
    - xpos/ypos <= shadow values held before that edge.
    - update<=1.
    - click<=click_pend, and click_pend<=0.
  - COMMIT -> PENDING if new_event or l_rise occurs on that edge; otherwise -> IDLE.
- Simultaneous events on the COMMIT-ending edge:
  - A new sample loads the shadow regs but is not committed; it waits for the next frame.
  - An l_rise keeps click_pend=1 for the next frame. It is not reported in the current click.
- No vb_rise is ever missed while in PENDING. If vblnk is already high on entry, the commit waits for the next frame.
- update and click are high for one cycle only, and 0 in every other cycle.
- Reset mid-operation (any state): all of the above return to their reset values on the next edge; pending data is discarded.

## Timing
- vblnk sampled 0 at edge k-1 and 1 at edge k, with state PENDING: state=COMMIT after edge k. xpos/ypos/update/click change at edge k+1.
- Latency from the first vblnk=1 sample to the outputs: 2 cycles.
- Maximum one commit per frame.
- Outputs are fully registered; no combinational path from any input to any output.

## Configuration
- MOUSE_CLAMP_EN defined: clamping as described above.
- MOUSE_CLAMP_EN not defined: clamp() is the identity. Raw 12-bit values pass unmodified, and H_ACTIVE/V_ACTIVE are unused.
- All other behaviour is identical in both builds.

## Structure
- vga_pkg holds the HOR_PIXELS/VER_PIXELS constants that serve as parameter defaults.
- vga_pkg also holds typedef enum logic [1:0] {IDLE, PENDING, COMMIT} mouse_pos_state_t.
- Sub-module edge_rise: registered previous value plus rising-edge output. Instantiated twice, for vblnk and left.

## Test plan
- Reset release, no events, 3 frames -> xpos=0, ypos=0; update and click never asserted.
- new_event with (100,200) mid-frame -> outputs unchanged until vblnk rises, then xpos=100, ypos=200 exactly 2 cycles after the first vblnk=1 sample; update=1 for one cycle, click=0.
- Three samples (10,10), (20,20), (30,30) in one frame -> a single commit of (30,30).
- Sample (900,700) -> commit of (799,599) with MOUSE_CLAMP_EN; commit of (900,700) without it.
- left pulse mid-frame -> at the next vblnk rise, update=1 and click=1 on the same cycle, xpos/ypos unchanged. A left rise on the COMMIT-ending edge -> click=0 now, click=1 at the next frame.
- rst asserted while in PENDING with sample (50,50) -> outputs 0 next cycle; the following vblnk rise produces no update.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, mouse position FSM states and the position clamp helper.
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} mouse_pos_state_t;

  // Saturate v to lim-1; a 13-bit limit of 4096 makes this the identity for any 12-bit v.
  function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [12:0] lim);
    if ({1'b0, v} >= lim)
      return 12'(lim - 13'd1);
    else
      return v;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: registers the previous input level and flags a 0->1 transition.
module edge_rise (
  input  logic clk40MHz,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_d_reg;

  always_ff @(posedge clk40MHz) begin
    if (rst)
      din_d_reg <= 1'b0;
    else
      din_d_reg <= din;
  end

  assign rise = din & ~din_d_reg;

endmodule

// File: rtl/mouse_pos_ctl.sv
// Frame-synchronous mouse position stage: shadows (optionally clamped) samples and commits them at vblank rise.
// Define MOUSE_CLAMP_EN to clamp positions to H_ACTIVE x V_ACTIVE; otherwise raw values pass through.
module mouse_pos_ctl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = HOR_PIXELS,
  parameter int V_ACTIVE = VER_PIXELS
) (
  input  logic        clk40MHz,
  input  logic        rst,
  input  logic [11:0] xpos_raw,
  input  logic [11:0] ypos_raw,
  input  logic        new_event,
  input  logic        left,
  input  logic        vblnk,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        update,
  output logic        click
);

`ifdef MOUSE_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  localparam logic [12:0] X_LIM = CLAMP_ON ? 13'(H_ACTIVE) : 13'h1000;
  localparam logic [12:0] Y_LIM = CLAMP_ON ? 13'(V_ACTIVE) : 13'h1000;

  logic vb_rise;
  logic l_rise;

  edge_rise u_vblnk_rise (
    .clk40MHz (clk40MHz),
    .rst      (rst),
    .din      (vblnk),
    .rise     (vb_rise)
  );

  edge_rise u_left_rise (
    .clk40MHz (clk40MHz),
    .rst      (rst),
    .din      (left),
    .rise     (l_rise)
  );

  mouse_pos_state_t state_reg, state_next;
  logic [11:0] shadow_x_reg, shadow_x_next;
  logic [11:0] shadow_y_reg, shadow_y_next;
  logic        click_pend_reg, click_pend_next;
  logic [11:0] xpos_reg, xpos_next;
  logic [11:0] ypos_reg, ypos_next;
  logic        update_reg, update_next;
  logic        click_reg, click_next;

  logic activity;
  assign activity = new_event | l_rise;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (activity) state_next = PENDING;
      PENDING: if (vb_rise)  state_next = COMMIT;
      COMMIT:  state_next = activity ? PENDING : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shadow_x_next   = shadow_x_reg;
    shadow_y_next   = shadow_y_reg;
    click_pend_next = click_pend_reg;
    xpos_next       = xpos_reg;
    ypos_next       = ypos_reg;
    update_next     = 1'b0;
    click_next      = 1'b0;

    if (new_event) begin
      shadow_x_next = clamp12(xpos_raw, X_LIM);
      shadow_y_next = clamp12(ypos_raw, Y_LIM);
    end

    // The commit takes the shadow values held before this edge; a press on this edge stays pending.
    if (state_reg == COMMIT) begin
      xpos_next       = shadow_x_reg;
      ypos_next       = shadow_y_reg;
      update_next     = 1'b1;
      click_next      = click_pend_reg;
      click_pend_next = 1'b0;
    end

    if (l_rise)
      click_pend_next = 1'b1;
  end

  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      state_reg      <= IDLE;
      shadow_x_reg   <= '0;
      shadow_y_reg   <= '0;
      click_pend_reg <= 1'b0;
      xpos_reg       <= '0;
      ypos_reg       <= '0;
      update_reg     <= 1'b0;
      click_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shadow_x_reg   <= shadow_x_next;
      shadow_y_reg   <= shadow_y_next;
      click_pend_reg <= click_pend_next;
      xpos_reg       <= xpos_next;
      ypos_reg       <= ypos_next;
      update_reg     <= update_next;
      click_reg      <= click_next;
    end
  end

  assign xpos   = xpos_reg;
  assign ypos   = ypos_reg;
  assign update = update_reg;
  assign click  = click_reg;

endmodule

// File: tb/tb_mouse_pos_ctl.sv
// Scoreboard bench for mouse_pos_ctl: the driver queues expected commits, a negedge monitor checks them.
module tb_mouse_pos_ctl;

  logic        clk40MHz = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos_raw = '0;
  logic [11:0] ypos_raw = '0;
  logic        new_event = 1'b0;
  logic        left = 1'b0;
  logic        vblnk = 1'b0;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        update;
  logic        click;

  mouse_pos_ctl dut (
    .clk40MHz  (clk40MHz),
    .rst       (rst),
    .xpos_raw  (xpos_raw),
    .ypos_raw  (ypos_raw),
    .new_event (new_event),
    .left      (left),
    .vblnk     (vblnk),
    .xpos      (xpos),
    .ypos      (ypos),
    .update    (update),
    .click     (click)
  );

  always #5 clk40MHz = ~clk40MHz;

`ifdef MOUSE_CLAMP_EN
  localparam logic [11:0] BIG_X = 12'd799;
  localparam logic [11:0] BIG_Y = 12'd599;
`else
  localparam logic [11:0] BIG_X = 12'd900;
  localparam logic [11:0] BIG_Y = 12'd700;
`endif

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic        c;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk40MHz) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every update pulse must match the oldest queued commit, including its cycle.
  always @(negedge clk40MHz) begin
    if (click && !update)
      check("click_without_update", int'(update), 1);
    if (update) begin
      if (exp_q.size() == 0) begin
        check("unexpected_update", int'(update), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("commit_x", int'(xpos), int'(e.x));
        check("commit_y", int'(ypos), int'(e.y));
        check("commit_click", int'(click), int'(e.c));
        check("commit_cycle", cyc, e.cyc);
        $display("commit: cycle %0d x=%0d y=%0d click=%0d", cyc, xpos, ypos, click);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk40MHz);
  endtask

  task automatic sample(input logic [11:0] x, input logic [11:0] y);
    xpos_raw  = x;
    ypos_raw  = y;
    new_event = 1'b1;
    tick(1);
    new_event = 1'b0;
  endtask

  task automatic push_exp(input logic [11:0] x, input logic [11:0] y, input logic c);
    exp_t e;
    e.x   = x;
    e.y   = y;
    e.c   = c;
    e.cyc = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic frame(input bit expect_commit, input logic [11:0] x, input logic [11:0] y,
                       input logic c);
    vblnk = 1'b1;
    if (expect_commit) push_exp(x, y, c);
    tick(4);
    vblnk = 1'b0;
    tick(6);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_xpos"}, int'(xpos), 0);
    check({tag, "_ypos"}, int'(ypos), 0);
    check({tag, "_update"}, int'(update), 0);
    check({tag, "_click"}, int'(click), 0);
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    check_zero("reset");
    rst = 1'b0;
    tick(4);

    // Idle frames must never produce an update.
    repeat (3) frame(1'b0, 12'd0, 12'd0, 1'b0);

    // Single sample, held until the next vblank rise.
    tick(2);
    sample(12'd100, 12'd200);
    tick(5);
    check("hold_x_before_vblank", int'(xpos), 0);
    check("hold_update_before_vblank", int'(update), 0);
    frame(1'b1, 12'd100, 12'd200, 1'b0);

    // Only the last of several samples in a frame is committed.
    sample(12'd10, 12'd10);
    tick(2);
    sample(12'd20, 12'd20);
    tick(2);
    sample(12'd30, 12'd30);
    tick(3);
    frame(1'b1, 12'd30, 12'd30, 1'b0);

    // Out-of-range sample.
    sample(12'd900, 12'd700);
    tick(3);
    frame(1'b1, BIG_X, BIG_Y, 1'b0);

    // Button press alone: commit with click, position unchanged.
    left = 1'b1;
    tick(2);
    left = 1'b0;
    tick(2);
    frame(1'b1, BIG_X, BIG_Y, 1'b1);

    // Press and new sample on the COMMIT-ending edge both defer to the next frame.
    sample(12'd5, 12'd6);
    tick(2);
    vblnk = 1'b1;
    push_exp(12'd5, 12'd6, 1'b0);
    tick(1);
    left      = 1'b1;
    new_event = 1'b1;
    xpos_raw  = 12'd7;
    ypos_raw  = 12'd8;
    tick(1);
    new_event = 1'b0;
    tick(2);
    left = 1'b0;
    tick(2);
    vblnk = 1'b0;
    tick(6);
    frame(1'b1, 12'd7, 12'd8, 1'b1);

    // Reset while pending discards the sample.
    sample(12'd50, 12'd50);
    tick(2);
    rst = 1'b1;
    tick(1);
    check_zero("midreset");
    rst = 1'b0;
    tick(2);
    frame(1'b0, 12'd0, 12'd0, 1'b0);
    frame(1'b0, 12'd0, 12'd0, 1'b0);
    check("post_reset_xpos", int'(xpos), 0);

    tick(5);
    check("all_commits_seen", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
